lns_mac: RTL and testbench

// - Single-lane logarithmic-number-system (LNS) multiply-accumulate unit with a valid/enable handshake.
// - Each accepted operand pair (natural or log domain) is multiplied in the log domain by adding logs.
// - The product is converted back to linear and added to a signed accumulator.
// - The accumulator is presented in natural or log form; the block sits between an operand streamer and a result sink.

---
 rtl/lns_mac_if.sv | 30 +++
 rtl/lns_mac.sv | 248 ++++++++++++++++++++++++
 tb/tb_lns_mac.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lns_mac_if.sv
// Operand-stream and result-sink handshake bundle for lns_mac.
// The master modport is the streamer/sink side and the slave modport is the MAC side.
interface lns_mac_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 23
);
    logic                data_in_valid;
    logic                data_in_enable;
    logic [IN_BITS:0]    data_in_x;
    logic [IN_BITS:0]    data_in_y;
    logic                data_in_x_nat_sign;
    logic                data_in_y_nat_sign;
    logic                data_in_nat;
    logic                data_out_nat;
    logic                data_out_enable;
    logic                data_out_valid;
    logic [OUT_BITS:0]   data_out;

    modport master (
        output data_in_valid, data_in_x, data_in_y, data_in_x_nat_sign,
               data_in_y_nat_sign, data_in_nat, data_out_nat, data_out_enable,
        input  data_in_enable, data_out_valid, data_out
    );

    modport slave (
        input  data_in_valid, data_in_x, data_in_y, data_in_x_nat_sign,
               data_in_y_nat_sign, data_in_nat, data_out_nat, data_out_enable,
        output data_in_enable, data_out_valid, data_out
    );
endinterface

// File: rtl/lns_mac.sv
// Single-lane LNS multiply-accumulate: Mitchell log, log-domain multiply, antilog, accumulate.
// Optional feature macro LNS_MAC_SAT_EN: saturating antilog/accumulate instead of wrap-around.
module lns_mac #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 23,
    parameter int LOG_FRAC = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    lns_mac_if.slave    bus
);
    localparam int OP_W  = IN_BITS + 1;
    localparam int PL_W  = IN_BITS + 2;
    localparam int ACC_W = OUT_BITS + 1;
    localparam int K_W   = $clog2(ACC_W);
    localparam int ML_W  = K_W + LOG_FRAC;
    localparam int I_W   = PL_W - LOG_FRAC;
    localparam int SH_W  = I_W + 2;

    localparam logic [OP_W-1:0]  ZERO_CODE = {1'b1, {(OP_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOG  = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Mitchell approximation: leading-one index as integer part, the bits below it as fraction.
    function automatic logic [ML_W-1:0] mitchell_log(input logic [ACC_W-1:0] mag);
        logic [K_W-1:0]            k;
        logic [ACC_W-1:0]          rem;
        logic [ACC_W+LOG_FRAC-1:0] ext;
        k = {K_W{1'b0}};
        for (int i = 0; i < ACC_W; i++) begin
            k = mag[i] ? K_W'(i) : k;
        end
        rem = mag & ~(ACC_ONE << k);
        ext = {rem, {LOG_FRAC{1'b0}}} >> k;
        return {k, ext[LOG_FRAC-1:0]};
    endfunction

    state_t             state_r;
    logic               in_enable_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   data_out_r;
    logic [ACC_W-1:0]   acc_r;
    logic [OP_W-1:0]    op_x_r;
    logic [OP_W-1:0]    op_y_r;
    logic               nat_sign_x_r;
    logic               nat_sign_y_r;
    logic               in_nat_r;
    logic               out_nat_r;
    logic [OP_W-1:0]    log_x_r;
    logic [OP_W-1:0]    log_y_r;
    logic               sgn_x_r;
    logic               sgn_y_r;
    logic               zero_x_r;
    logic               zero_y_r;
    logic [PL_W-1:0]    prod_log_r;
    logic               prod_sgn_r;
    logic               prod_zero_r;

    logic [OP_W-1:0]    mag_x_s;
    logic [OP_W-1:0]    mag_y_s;
    logic [OP_W-1:0]    log_x_s;
    logic [OP_W-1:0]    log_y_s;
    logic               sgn_x_s;
    logic               sgn_y_s;
    logic               zero_x_s;
    logic               zero_y_s;
    logic [I_W-1:0]     int_s;
    logic [SH_W-1:0]    shift_s;
    logic [ACC_W-1:0]   mant_s;
    logic [ACC_W-1:0]   mag_s;
    logic [ACC_W-1:0]   term_s;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [ACC_W-1:0]   acc_mag_s;
    logic [ML_W-1:0]    acc_log_s;
    logic [ACC_W-1:0]   out_fmt_s;
`ifdef LNS_MAC_SAT_EN
    logic [ACC_W:0]     sum_s;
`endif

    assign bus.data_in_enable = in_enable_r;
    assign bus.data_out_valid = out_valid_r;
    assign bus.data_out       = data_out_r;

    // Operand decode: natural operands go through Mitchell, log operands pass straight through.
    always_comb begin
        mag_x_s = op_x_r[OP_W-1] ? ({OP_W{1'b0}} - op_x_r) : op_x_r;
        mag_y_s = op_y_r[OP_W-1] ? ({OP_W{1'b0}} - op_y_r) : op_y_r;
        if (in_nat_r) begin
            log_x_s  = OP_W'(mitchell_log(ACC_W'(mag_x_s)));
            log_y_s  = OP_W'(mitchell_log(ACC_W'(mag_y_s)));
            sgn_x_s  = op_x_r[OP_W-1];
            sgn_y_s  = op_y_r[OP_W-1];
            zero_x_s = (mag_x_s == {OP_W{1'b0}});
            zero_y_s = (mag_y_s == {OP_W{1'b0}});
        end else begin
            log_x_s  = op_x_r;
            log_y_s  = op_y_r;
            sgn_x_s  = nat_sign_x_r;
            sgn_y_s  = nat_sign_y_r;
            zero_x_s = (op_x_r == ZERO_CODE);
            zero_y_s = (op_y_r == ZERO_CODE);
        end
    end

    // Antilog of the product and the accumulator update.
    always_comb begin
        int_s   = prod_log_r[PL_W-1:LOG_FRAC];
        shift_s = {{2{int_s[I_W-1]}}, int_s} - SH_W'(LOG_FRAC);
        mant_s  = {{(ACC_W-LOG_FRAC-1){1'b0}}, 1'b1, prod_log_r[LOG_FRAC-1:0]};
        if (shift_s[SH_W-1]) begin
            mag_s = mant_s >> ({SH_W{1'b0}} - shift_s);
        end else begin
            mag_s = mant_s << shift_s;
        end
        if (prod_zero_r) begin
            term_s = {ACC_W{1'b0}};
        end
`ifdef LNS_MAC_SAT_EN
        else if ($signed(shift_s) >= $signed(SH_W'(OUT_BITS - LOG_FRAC))) begin
            term_s = prod_sgn_r ? ACC_MIN : ACC_MAX;
        end
`endif
        else if (prod_sgn_r) begin
            term_s = {ACC_W{1'b0}} - mag_s;
        end else begin
            term_s = mag_s;
        end
`ifdef LNS_MAC_SAT_EN
        sum_s = {acc_r[ACC_W-1], acc_r} + {term_s[ACC_W-1], term_s};
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            acc_nxt_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
        end
`else
        acc_nxt_s = acc_r + term_s;
`endif
    end

    // Result formatting: linear accumulator, or sign plus Mitchell log of its magnitude.
    always_comb begin
        acc_mag_s = acc_r[ACC_W-1] ? ({ACC_W{1'b0}} - acc_r) : acc_r;
        acc_log_s = mitchell_log(acc_mag_s);
        if (out_nat_r) begin
            out_fmt_s = acc_r;
        end else if (acc_r == {ACC_W{1'b0}}) begin
            out_fmt_s = ACC_MIN;
        end else begin
            out_fmt_s = {acc_r[ACC_W-1], (ACC_W-1)'(acc_log_s)};
        end
    end

    // Control FSM and pipeline registers; clr overrides every state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            in_enable_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            data_out_r   <= {ACC_W{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
            op_x_r       <= {OP_W{1'b0}};
            op_y_r       <= {OP_W{1'b0}};
            nat_sign_x_r <= 1'b0;
            nat_sign_y_r <= 1'b0;
            in_nat_r     <= 1'b0;
            out_nat_r    <= 1'b0;
            log_x_r      <= {OP_W{1'b0}};
            log_y_r      <= {OP_W{1'b0}};
            sgn_x_r      <= 1'b0;
            sgn_y_r      <= 1'b0;
            zero_x_r     <= 1'b0;
            zero_y_r     <= 1'b0;
            prod_log_r   <= {PL_W{1'b0}};
            prod_sgn_r   <= 1'b0;
            prod_zero_r  <= 1'b0;
        end else if (clr) begin
            state_r     <= ST_IDLE;
            in_enable_r <= 1'b0;
            out_valid_r <= 1'b0;
            data_out_r  <= {ACC_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.data_in_valid && in_enable_r) begin
                        op_x_r       <= bus.data_in_x;
                        op_y_r       <= bus.data_in_y;
                        nat_sign_x_r <= bus.data_in_x_nat_sign;
                        nat_sign_y_r <= bus.data_in_y_nat_sign;
                        in_nat_r     <= bus.data_in_nat;
                        out_nat_r    <= bus.data_out_nat;
                        in_enable_r  <= 1'b0;
                        state_r      <= ST_LOG;
                    end else begin
                        in_enable_r  <= 1'b1;
                    end
                end
                ST_LOG: begin
                    log_x_r  <= log_x_s;
                    log_y_r  <= log_y_s;
                    sgn_x_r  <= sgn_x_s;
                    sgn_y_r  <= sgn_y_s;
                    zero_x_r <= zero_x_s;
                    zero_y_r <= zero_y_s;
                    state_r  <= ST_MUL;
                end
                ST_MUL: begin
                    prod_log_r  <= {log_x_r[OP_W-1], log_x_r} + {log_y_r[OP_W-1], log_y_r};
                    prod_sgn_r  <= sgn_x_r ^ sgn_y_r;
                    prod_zero_r <= zero_x_r | zero_y_r;
                    state_r     <= ST_ACC;
                end
                ST_ACC: begin
                    acc_r   <= acc_nxt_s;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    // First OUT cycle latches the result; later cycles wait for the sink.
                    if (!out_valid_r) begin
                        data_out_r  <= out_fmt_s;
                        out_valid_r <= 1'b1;
                    end else if (bus.data_out_enable) begin
                        out_valid_r <= 1'b0;
                        in_enable_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_OUT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_enable_r <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lns_mac.sv
// Directed-vector bench for lns_mac with hand-computed expected results.
// Overflow expectations follow LNS_MAC_SAT_EN when it is defined.
module tb_lns_mac;
    logic clk = 1'b0;
    logic rstn;
    logic clr;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lns_mac_if #(.IN_BITS(8), .OUT_BITS(23)) bus ();

    lns_mac #(.IN_BITS(8), .OUT_BITS(23), .LOG_FRAC(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .bus   (bus)
    );

    task automatic check_value(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [8:0] x, input logic [8:0] y, input logic xs,
                          input logic ys, input logic nat, input logic onat,
                          output logic rdy, output logic busy_en, output int lat,
                          output logic signed [31:0] dout);
        int n = 0;
        while (bus.data_in_enable !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rdy = bus.data_in_enable;
        bus.data_in_x          = x;
        bus.data_in_y          = y;
        bus.data_in_x_nat_sign = xs;
        bus.data_in_y_nat_sign = ys;
        bus.data_in_nat        = nat;
        bus.data_out_nat       = onat;
        bus.data_in_valid      = 1'b1;
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        busy_en = bus.data_in_enable;
        lat = 0;
        while (bus.data_out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = $signed(bus.data_out);
    endtask

    task automatic do_op(input string tag, input logic [8:0] x, input logic [8:0] y,
                         input logic xs, input logic ys, input logic nat, input logic onat,
                         input int exp, input bit drain);
        logic rdy;
        logic busy_en;
        int   lat;
        logic signed [31:0] dout;
        run_op(x, y, xs, ys, nat, onat, rdy, busy_en, lat, dout);
        check_value({tag, "_rdy"}, rdy, 1);
        check_value({tag, "_busy"}, busy_en, 0);
        check_value({tag, "_lat"}, lat, 4);
        check_value({tag, "_out"}, dout, exp);
        if (drain) begin
            @(posedge clk); #1;
            check_value({tag, "_vdrop"}, bus.data_out_valid, 0);
            check_value({tag, "_ready"}, bus.data_in_enable, 1);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        logic rdy;
        logic busy_en;
        int   lat;
        logic signed [31:0] dout;
        int   exp_ovf;

        rstn = 1'b0;
        clr  = 1'b0;
        bus.data_in_valid      = 1'b0;
        bus.data_in_x          = 9'd0;
        bus.data_in_y          = 9'd0;
        bus.data_in_x_nat_sign = 1'b0;
        bus.data_in_y_nat_sign = 1'b0;
        bus.data_in_nat        = 1'b1;
        bus.data_out_nat       = 1'b1;
        bus.data_out_enable    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out", $signed(bus.data_out), 0);
        check_value("rst_valid", bus.data_out_valid, 0);
        check_value("rst_en", bus.data_in_enable, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        check_value("rel_en", bus.data_in_enable, 1);

        do_op("nat_4x8",   9'd4,   9'd16 >> 1, 1'b0, 1'b0, 1'b1, 1'b1, 32, 1'b1);
        do_op("nat_m2x16", 9'h1FE, 9'd16,      1'b0, 1'b0, 1'b1, 1'b1, 0,  1'b1);
        do_op("log_pos",   9'b000110000, 9'b000100000, 1'b0, 1'b0, 1'b0, 1'b1, 32, 1'b1);
        do_op("log_neg",   9'b000110000, 9'b000100000, 1'b1, 1'b0, 1'b0, 1'b1, 0,  1'b1);
        do_op("nat_4x8b",  9'd4,   9'd8,   1'b0, 1'b0, 1'b1, 1'b1, 32, 1'b1);
        do_op("zero_nat",  9'd0,   9'd100, 1'b0, 1'b0, 1'b1, 1'b1, 32, 1'b1);
        do_op("zero_log",  9'd0,   9'd100, 1'b0, 1'b0, 1'b1, 1'b0, 80, 1'b1);
        do_op("log_zcode", 9'h100, 9'd32,  1'b0, 1'b0, 1'b0, 1'b1, 32, 1'b1);

        pulse_clr();
        check_value("clr_valid", bus.data_out_valid, 0);
        do_op("clr_acc",   9'd0,   9'd5,   1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        do_op("acc0_log",  9'd0,   9'd5,   1'b0, 1'b0, 1'b1, 1'b0, -8388608, 1'b1);

        // Sink stalls while the streamer keeps offering an operand.
        bus.data_out_enable = 1'b0;
        do_op("bp", 9'd4, 9'd8, 1'b0, 1'b0, 1'b1, 1'b1, 32, 1'b0);
        bus.data_in_x     = 9'd1;
        bus.data_in_y     = 9'd1;
        bus.data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_value("bp_hold_valid", bus.data_out_valid, 1);
            check_value("bp_hold_out", $signed(bus.data_out), 32);
            check_value("bp_hold_en", bus.data_in_enable, 0);
        end
        bus.data_in_valid   = 1'b0;
        bus.data_out_enable = 1'b1;
        @(posedge clk); #1;
        check_value("bp_rel_valid", bus.data_out_valid, 0);
        check_value("bp_rel_en", bus.data_in_enable, 1);

        do_op("busy_ign",  9'd1,   9'd1,   1'b0, 1'b0, 1'b1, 1'b1, 33, 1'b1);
        do_op("neg_log",   9'h1F8, 9'd8,   1'b0, 1'b0, 1'b1, 1'b0, -8388529, 1'b1);
        do_op("mit_3x5",   9'd3,   9'd5,   1'b0, 1'b0, 1'b1, 1'b1, -17, 1'b1);

        // Reset asserted while an operation is in flight.
        bus.data_in_x     = 9'd1;
        bus.data_in_y     = 9'd1;
        bus.data_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check_value("mid_rst_out", $signed(bus.data_out), 0);
        check_value("mid_rst_valid", bus.data_out_valid, 0);
        check_value("mid_rst_en", bus.data_in_enable, 0);
        @(negedge clk) rstn = 1'b1;
        do_op("post_rst",  9'd1,   9'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);

        // 255*255 adds 61440 per operation; the 137th pushes past 2^23-1.
        pulse_clr();
`ifdef LNS_MAC_SAT_EN
        exp_ovf = 8388607;
`else
        exp_ovf = -8175616;
`endif
        for (int i = 0; i < 140; i++) begin
            run_op(9'd255, 9'd255, 1'b0, 1'b0, 1'b1, 1'b1, rdy, busy_en, lat, dout);
            if (i == 135) begin
                check_value("ovf_136", dout, 8355840);
            end
            @(posedge clk); #1;
        end
        check_value("ovf_lat", lat, 4);
        check_value("ovf_140", dout, exp_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
